tff_count_sequencer: RTL and testbench

Controller that sequences a bank of WIDTH toggle flip-flops as a programmable up/down run counter. It owns the toggle-enable vector driving the bank: it loads a start value by toggle-to-load, steps it one count per cycle, and stops at a latched endpoint. Pause, resume and abort are available through a start/stop handshake. It is the sequencing layer above the T-flop primitives and is used wherever a bounded count run is needed.

---
 rtl/tff_count_sequencer.sv | 104 ++++++++++
 tb/tb_tff_count_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tff_count_sequencer.sv
// Sequencer for a bank of WIDTH T-flops run as a bounded up/down counter.
// The bank is modelled here: count toggles by the t_en vector on each clock edge.
module tff_count_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic [WIDTH-1:0] init_new;
    logic [WIDTH-1:0] endpoint;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;

    assign init_new = dir ? '0 : limit;
    assign endpoint = dir_q ? limit_q : '0;

    // Ripple toggle chains: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_tog    = '0;
        dn_tog    = '0;
        up_tog[0] = 1'b1;
        dn_tog[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            up_tog[i] = up_tog[i-1] & count_q[i-1];
            dn_tog[i] = dn_tog[i-1] & ~count_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        t_en    = '0;
        dir_d   = dir_q;
        limit_d = limit_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    t_en    = count_q ^ init_new;
                    dir_d   = dir;
                    limit_d = limit;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else if (count_q == endpoint) begin
                    state_d = StDone;
                end else begin
                    t_en = dir_q ? up_tog : dn_tog;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            dir_q   <= 1'b0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q ^ t_en;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    assign count   = count_q;
    assign count_n = ~count_q;
    assign busy    = (state_q == StRun) || (state_q == StPause);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed self-checking bench for tff_count_sequencer (WIDTH=4).
module tb_tff_count_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic [3:0] limit;
    logic [3:0] t_en;
    logic [3:0] count;
    logic [3:0] count_n;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    tff_count_sequencer #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .limit   (limit),
        .t_en    (t_en),
        .count   (count),
        .count_n (count_n),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks count, count_n, busy and done together.
    task automatic chk_st(input string tag, input logic [3:0] c, input logic b, input logic d);
        chk({tag, ".count"}, {28'd0, count}, {28'd0, c});
        chk({tag, ".count_n"}, {28'd0, count_n}, {28'd0, ~c});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        dir   = 1'b0;
        limit = 4'd0;
        #1;
        chk_st("reset", 4'd0, 1'b0, 1'b0);
        chk("reset.t_en", {28'd0, t_en}, 32'd0);
        #12;
        rst = 1'b0;
        tick();

        // Up run 0..5
        dir   = 1'b1;
        limit = 4'd5;
        start = 1'b1;
        #1;
        chk("up5.load_t_en", {28'd0, t_en}, 32'd0);
        tick();
        start = 1'b0;
        chk_st("up5.e0", 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_st("up5.step", 4'(k), 1'b1, 1'b0);
        end
        tick();
        chk_st("up5.done", 4'd5, 1'b0, 1'b1);
        tick();
        chk_st("up5.idle", 4'd5, 1'b0, 1'b0);

        // Down run from 9, dir/limit changed mid-run must not matter
        dir   = 1'b0;
        limit = 4'd9;
        start = 1'b1;
        #1;
        chk("dn9.load_t_en", {28'd0, t_en}, 32'hC);
        tick();
        start = 1'b0;
        dir   = 1'b1;
        limit = 4'd3;
        chk_st("dn9.e0", 4'd9, 1'b1, 1'b0);
        for (int k = 8; k >= 0; k--) begin
            tick();
            chk_st("dn9.step", 4'(k), 1'b1, 1'b0);
        end
        tick();
        chk_st("dn9.done", 4'd0, 1'b0, 1'b1);
        tick();
        chk_st("dn9.idle", 4'd0, 1'b0, 1'b0);

        // Up run to 15 with a pause at 7
        dir   = 1'b1;
        limit = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_st("up15.e0", 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) tick();
        chk_st("up15.at7", 4'd7, 1'b1, 1'b0);
        stop = 1'b1;
        #1;
        chk("up15.stop_t_en", {28'd0, t_en}, 32'd0);
        tick();
        stop = 1'b0;
        chk_st("up15.pause1", 4'd7, 1'b1, 1'b0);
        tick();
        chk_st("up15.pause2", 4'd7, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_st("up15.resume", 4'd7, 1'b1, 1'b0);
        for (int k = 8; k <= 15; k++) begin
            tick();
            chk_st("up15.step", 4'(k), 1'b1, 1'b0);
        end
        tick();
        chk_st("up15.done", 4'd15, 1'b0, 1'b1);
        tick();
        chk_st("up15.idle", 4'd15, 1'b0, 1'b0);
        tick();
        chk_st("up15.nowrap", 4'd15, 1'b0, 1'b0);

        // Down run from 6 aborted at 3
        dir   = 1'b0;
        limit = 4'd6;
        start = 1'b1;
        #1;
        chk("dn6.load_t_en", {28'd0, t_en}, 32'h9);
        tick();
        start = 1'b0;
        chk_st("dn6.e0", 4'd6, 1'b1, 1'b0);
        for (int k = 5; k >= 3; k--) begin
            tick();
            chk_st("dn6.step", 4'(k), 1'b1, 1'b0);
        end
        stop = 1'b1;
        tick();
        chk_st("dn6.pause", 4'd3, 1'b1, 1'b0);
        tick();
        stop = 1'b0;
        chk_st("dn6.abort", 4'd3, 1'b0, 1'b0);
        tick();
        chk_st("dn6.idle", 4'd3, 1'b0, 1'b0);

        // Zero-length up run
        dir   = 1'b1;
        limit = 4'd0;
        start = 1'b1;
        #1;
        chk("z.load_t_en", {28'd0, t_en}, 32'h3);
        tick();
        start = 1'b0;
        chk_st("z.run", 4'd0, 1'b1, 1'b0);
        tick();
        chk_st("z.done", 4'd0, 1'b0, 1'b1);
        tick();
        chk_st("z.idle", 4'd0, 1'b0, 1'b0);

        // start+stop together in IDLE is ignored
        limit = 4'd7;
        start = 1'b1;
        stop  = 1'b1;
        #1;
        chk("ss.t_en", {28'd0, t_en}, 32'd0);
        tick();
        chk_st("ss.idle", 4'd0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chk_st("ss.idle2", 4'd0, 1'b0, 1'b0);

        // Async reset mid-run at count 10
        dir   = 1'b1;
        limit = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk_st("ar.at10", 4'd10, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_st("ar.reset", 4'd0, 1'b0, 1'b0);
        chk("ar.t_en", {28'd0, t_en}, 32'd0);
        #3;
        rst = 1'b0;
        tick();
        chk_st("ar.after", 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
